fwrisc_mem_arbiter: RTL and testbench

Two-to-one memory-port arbiter that lets a single-ported memory serve both the fwrisc core's instruction-fetch bus and its data bus. It sits between the core's `i*`/`d*` ports and a unified memory port `m*`. It registers the winning request, holds it until the memory completes, and routes the response back to the winning requester. Data accesses have priority, and a bounded-burst guard keeps instruction fetch from starving.

---
 rtl/fwrisc_mem_arb_pkg.sv | 39 +++
 rtl/fwrisc_mem_arbiter_if.sv | 36 +++
 rtl/fwrisc_mem_arb_prio.sv | 41 ++++
 rtl/fwrisc_mem_arbiter.sv | 79 +++++++
 tb/tb_fwrisc_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwrisc_mem_arb_pkg.sv
// Shared types for the fwrisc instruction/data memory-port arbiter.
// Holds the FSM state encoding, the starvation-counter width and request builders.
package fwrisc_mem_arb_pkg;

  localparam int unsigned MEM_ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } mem_arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
  } mem_req_t;

  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.addr  = addr;
    r.wdata = 32'h0;
    r.wstb  = 4'h0;
    r.write = 1'b0;
    return r;
  endfunction

  function automatic mem_req_t data_req(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] wstb, input logic write);
    mem_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstb  = wstb;
    r.write = write;
    return r;
  endfunction

endpackage

// File: rtl/fwrisc_mem_arbiter_if.sv
// Bundle of the core fetch bus (i*), core data bus (d*) and unified memory port (m*).
// slave is the arbiter's view; master is the core-plus-memory environment's view.
interface fwrisc_mem_arbiter_if;

  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;

  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dready;

  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstb;
  logic        mwrite;
  logic        mvalid;
  logic [31:0] mrdata;
  logic        mready;

  modport slave (
    input  iaddr, ivalid, daddr, dwdata, dwstb, dwrite, dvalid, mrdata, mready,
    output idata, iready, drdata, dready, maddr, mwdata, mwstb, mwrite, mvalid
  );

  modport master (
    output iaddr, ivalid, daddr, dwdata, dwstb, dwrite, dvalid, mrdata, mready,
    input  idata, iready, drdata, dready, maddr, mwdata, mwstb, mwrite, mvalid
  );

endinterface

// File: rtl/fwrisc_mem_arb_prio.sv
// Priority decision for the memory arbiter: data wins unless fetch has waited
// through D_BURST_MAX consecutive data grants.
module fwrisc_mem_arb_prio
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ivalid,
  input  logic dvalid,
  input  logic gnt_stb,
  output logic gnt_i,
  output logic gnt_d
);

  localparam logic [MEM_ARB_CNT_W-1:0] DMax = MEM_ARB_CNT_W'(D_BURST_MAX);

  logic [MEM_ARB_CNT_W-1:0] r_dcnt;
  logic                     w_starve;

  assign w_starve = ivalid && (r_dcnt >= DMax);
  assign gnt_d    = gnt_stb && dvalid && !w_starve;
  assign gnt_i    = gnt_stb && ivalid && !gnt_d;

  // Counts data grants that overtook a pending fetch; any other grant clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (gnt_d) begin
      if (!ivalid) begin
        r_dcnt <= '0;
      end else if (r_dcnt < DMax) begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end else if (gnt_i) begin
      r_dcnt <= '0;
    end
  end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between fwrisc fetch and data buses.
// The winning request is registered onto m* and held until mready.
module fwrisc_mem_arbiter
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  fwrisc_mem_arbiter_if.slave   bus
);

  mem_arb_state_e r_state;
  mem_req_t       r_req;
  logic           r_mvalid;

  logic           w_gnt_stb;
  logic           w_gnt_i;
  logic           w_gnt_d;

  assign w_gnt_stb = (r_state == IDLE);

  fwrisc_mem_arb_prio #(
    .D_BURST_MAX (D_BURST_MAX)
  ) u_prio (
    .clock   (clock),
    .reset   (reset),
    .ivalid  (bus.ivalid),
    .dvalid  (bus.dvalid),
    .gnt_stb (w_gnt_stb),
    .gnt_i   (w_gnt_i),
    .gnt_d   (w_gnt_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_mvalid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_d) begin
            r_req    <= data_req(bus.daddr, bus.dwdata, bus.dwstb, bus.dwrite);
            r_mvalid <= 1'b1;
            r_state  <= BUSY_D;
          end else if (w_gnt_i) begin
            r_req    <= fetch_req(bus.iaddr);
            r_mvalid <= 1'b1;
            r_state  <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // Request fields stay put; only mvalid drops when the memory completes.
          if (bus.mready) begin
            r_mvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_mvalid <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.maddr  = r_req.addr;
  assign bus.mwdata = r_req.wdata;
  assign bus.mwstb  = r_req.wstb;
  assign bus.mwrite = r_req.write;
  assign bus.mvalid = r_mvalid;

  assign bus.iready = (r_state == BUSY_I) && bus.mready;
  assign bus.dready = (r_state == BUSY_D) && bus.mready;
  assign bus.idata  = bus.iready ? bus.mrdata : 32'h0;
  assign bus.drdata = bus.dready ? bus.mrdata : 32'h0;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Self-checking bench for fwrisc_mem_arbiter: requester drivers, a wait-state memory
// model and an in-order scoreboard of expected memory transactions.
module tb_fwrisc_mem_arbiter;

  logic clock;
  logic reset;

  fwrisc_mem_arbiter_if ifc ();

  fwrisc_mem_arbiter #(
    .D_BURST_MAX (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
  } req_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
    int          waits;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_mwstb;
    logic        exp_mwrite;
  } vec_t;

  req_t iq[$];
  req_t dq[$];
  exp_t sb[$];
  int   done_cyc[$];

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mem_wait = 0;
  int   wcnt;
  logic mem_stray = 1'b0;
  int   mv_cyc = 0;
  logic prev_done = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_C3C3);
  endfunction

  // Memory model: completes after mem_wait extra cycles of mvalid.
  always @(posedge clock or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (!ifc.mvalid || ifc.mready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign ifc.mready = (ifc.mvalid && (wcnt == mem_wait)) || mem_stray;
  assign ifc.mrdata = mem_rd(ifc.maddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Fetch requester: holds the head request until iready.
  initial begin
    ifc.ivalid = 1'b0;
    ifc.iaddr  = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (iq.size() > 0) begin
        ifc.ivalid = 1'b1;
        ifc.iaddr  = iq[0].addr;
      end else begin
        ifc.ivalid = 1'b0;
        ifc.iaddr  = 32'h0;
      end
      @(negedge clock);
      if (ifc.iready && iq.size() > 0) void'(iq.pop_front());
    end
  end

  // Data requester: holds the head request until dready.
  initial begin
    ifc.dvalid = 1'b0;
    ifc.daddr  = 32'h0;
    ifc.dwdata = 32'h0;
    ifc.dwstb  = 4'h0;
    ifc.dwrite = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (dq.size() > 0) begin
        ifc.dvalid = 1'b1;
        ifc.daddr  = dq[0].addr;
        ifc.dwdata = dq[0].wdata;
        ifc.dwstb  = dq[0].wstb;
        ifc.dwrite = dq[0].write;
      end else begin
        ifc.dvalid = 1'b0;
        ifc.daddr  = 32'h0;
        ifc.dwdata = 32'h0;
        ifc.dwstb  = 4'h0;
        ifc.dwrite = 1'b0;
      end
      @(negedge clock);
      if (ifc.dready && dq.size() > 0) void'(dq.pop_front());
    end
  end

  // Monitor: every mvalid cycle is checked against the scoreboard head.
  always @(negedge clock) begin
    if (reset) begin
      mv_cyc    = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("mvalid_drop_after_done", ifc.mvalid, 1'b0);
      prev_done = 1'b0;
      if (ifc.mvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", ifc.mvalid, 1'b0);
        end else begin
          chk("maddr", ifc.maddr, sb[0].addr);
          chk("mwrite", ifc.mwrite, sb[0].write);
          mv_cyc++;
          if (ifc.mready) begin
            chk("mwdata", ifc.mwdata, sb[0].wdata);
            chk("mwstb", ifc.mwstb, sb[0].wstb);
            chk("mvalid_cycles", mv_cyc, sb[0].waits + 1);
            if (sb[0].is_d) begin
              chk("dready", ifc.dready, 1'b1);
              chk("iready_on_data", ifc.iready, 1'b0);
              if (!sb[0].write) chk("drdata", ifc.drdata, sb[0].rdata);
            end else begin
              chk("iready", ifc.iready, 1'b1);
              chk("dready_on_fetch", ifc.dready, 1'b0);
              chk("idata", ifc.idata, sb[0].rdata);
            end
            void'(sb.pop_front());
            mv_cyc    = 0;
            prev_done = 1'b1;
            done_cyc.push_back(cyc);
          end
        end
      end
      if (!(ifc.mvalid && ifc.mready)) begin
        chk("stray_iready", ifc.iready, 1'b0);
        chk("stray_dready", ifc.dready, 1'b0);
      end
    end
  end

  task automatic push(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstb, input logic write, input int waits);
    exp_t e;
    req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstb  = wstb;
    r.write = write;
    e.is_d  = is_d;
    e.addr  = addr;
    e.wdata = is_d ? wdata : 32'h0;
    e.wstb  = is_d ? wstb : 4'h0;
    e.write = is_d ? write : 1'b0;
    e.waits = waits;
    e.rdata = mem_rd(addr);
    sb.push_back(e);
    if (is_d) dq.push_back(r);
    else iq.push_back(r);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() > 0 || iq.size() > 0 || dq.size() > 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    chk({"timeout_", name}, 32'(n >= 300), 32'h0);
    if (n >= 300) begin
      sb.delete();
      iq.delete();
      dq.delete();
    end
    @(posedge clock);
    #3;
  endtask

  task automatic chk_spacing(input string name, input int n_exp);
    chk({name, "_count"}, done_cyc.size(), n_exp);
    for (int k = 1; k < done_cyc.size(); k++)
      chk({name, "_spacing"}, done_cyc[k] - done_cyc[k-1], 2);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 0,
                32'h0000_0100, 32'h0, 4'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b1, 0,
                32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'h0, 1'b0, 3,
                32'h0000_4000, 32'hFFFF_FFFF, 4'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, 1,
                32'h0000_0104, 32'h0, 4'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0010, 32'hA5A5_5A5A, 4'hF, 1'b1, 2,
                32'h8000_0010, 32'hA5A5_5A5A, 4'hF, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 0,
                32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'b1100, 1'b0, 0,
                32'h0000_0000, 32'h0BAD_F00D, 4'b1100, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_1234, 32'h0, 4'b1000, 1'b1, 5,
                32'h0000_1234, 32'h0, 4'b1000, 1'b1};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mvalid", ifc.mvalid, 1'b0);
    chk("rst_maddr", ifc.maddr, 32'h0);
    chk("rst_mwstb", ifc.mwstb, 4'h0);
    chk("rst_iready", ifc.iready, 1'b0);
    @(posedge clock);
    #3;

    // Single fetch: one idle cycle of latency, then zero-wait completion.
    mem_wait = 0;
    push(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 0);
    @(posedge clock);
    #2;
    @(negedge clock);
    chk("fetch_not_yet_granted", ifc.mvalid, 1'b0);
    @(negedge clock);
    chk("fetch_mvalid", ifc.mvalid, 1'b1);
    chk("fetch_maddr", ifc.maddr, 32'h100);
    chk("fetch_iready", ifc.iready, 1'b1);
    chk("fetch_idata", ifc.idata, 32'hDEAD_BEEF);
    chk("fetch_dready", ifc.dready, 1'b0);
    wait_done("single_fetch");

    // Table of isolated transactions.
    for (int v = 0; v < 8; v++) begin
      exp_t e;
      req_t r;
      mem_wait = vecs[v].waits;
      e.is_d   = vecs[v].is_d;
      e.addr   = vecs[v].exp_maddr;
      e.wdata  = vecs[v].exp_mwdata;
      e.wstb   = vecs[v].exp_mwstb;
      e.write  = vecs[v].exp_mwrite;
      e.waits  = vecs[v].waits;
      e.rdata  = mem_rd(vecs[v].addr);
      r.addr   = vecs[v].addr;
      r.wdata  = vecs[v].wdata;
      r.wstb   = vecs[v].wstb;
      r.write  = vecs[v].write;
      sb.push_back(e);
      if (vecs[v].is_d) dq.push_back(r);
      else iq.push_back(r);
      wait_done($sformatf("vec%0d", v));
    end
    mem_wait = 0;

    // Simultaneous requests: data first, fetch after exactly one idle cycle.
    done_cyc.delete();
    push(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b1, 0);
    push(1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 0);
    wait_done("simultaneous");
    chk_spacing("simultaneous", 2);

    // Starvation guard: 4 data, fetch, 4 data, fetch, then remaining data.
    done_cyc.delete();
    for (int k = 0; k < 4; k++) push(1'b1, 32'h5000 + 32'(4 * k), 32'h0, 4'h0, 1'b0, 0);
    push(1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 0);
    for (int k = 4; k < 8; k++) push(1'b1, 32'h5000 + 32'(4 * k), 32'h0, 4'h0, 1'b0, 0);
    push(1'b0, 32'h604, 32'h0, 4'h0, 1'b0, 0);
    for (int k = 8; k < 10; k++) push(1'b1, 32'h5000 + 32'(4 * k), 32'h0, 4'h0, 1'b0, 0);
    wait_done("starvation");
    chk_spacing("starvation", 12);

    // Back-to-back fetches with ivalid held: one grant per two cycles.
    done_cyc.delete();
    for (int k = 0; k < 4; k++) push(1'b0, 32'h700 + 32'(4 * k), 32'h0, 4'h0, 1'b0, 0);
    wait_done("back_to_back");
    chk_spacing("back_to_back", 4);

    // Stray mready while idle must not produce a ready or a grant.
    mem_stray = 1'b1;
    @(negedge clock);
    chk("stray_idle_iready", ifc.iready, 1'b0);
    chk("stray_idle_dready", ifc.dready, 1'b0);
    @(negedge clock);
    chk("stray_idle_mvalid", ifc.mvalid, 1'b0);
    mem_stray = 1'b0;
    @(posedge clock);
    #3;

    // Reset in the middle of a stalled data write.
    mem_wait = 50;
    push(1'b1, 32'h3000, 32'hCAFE_F00D, 4'hF, 1'b1, 50);
    begin
      int n = 0;
      while (!ifc.mvalid && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("rst_mid_grant_seen", ifc.mvalid, 1'b1);
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_mvalid", ifc.mvalid, 1'b0);
    chk("rst_mid_maddr", ifc.maddr, 32'h0);
    chk("rst_mid_mwdata", ifc.mwdata, 32'h0);
    chk("rst_mid_mwstb", ifc.mwstb, 4'h0);
    chk("rst_mid_mwrite", ifc.mwrite, 1'b0);
    chk("rst_mid_dready", ifc.dready, 1'b0);
    chk("rst_mid_iready", ifc.iready, 1'b0);
    sb.delete();
    dq.delete();
    mem_wait = 0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("post_rst_mvalid", ifc.mvalid, 1'b0);
      chk("post_rst_dready", ifc.dready, 1'b0);
    end
    @(posedge clock);
    #3;

    // Arbiter still works after the abandoned transaction.
    push(1'b1, 32'h3004, 32'h0, 4'h0, 1'b0, 0);
    wait_done("post_reset_read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
